// File: rtl/fp_pkg.sv
// fp_pkg: shared FP rounding-mode, flag-index and format constants
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4,
        RM_DYN = 3'd7
    } rm_e;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam int SP_EXP_W  = 8;
    localparam int SP_FRAC_W = 23;
    localparam int DP_EXP_W  = 11;
    localparam int DP_FRAC_W = 52;

    // The instruction mode DYN defers to the dynamic fcsr.frm value.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// fp_round_decide: IEEE-754 round-increment decision from mode, sign, LSB and GRS
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic [2:0] grs_i,
    output logic       inc_o,
    output logic       illegal_o,
    output logic       inexact_o
);
    logic any_grs;

    assign any_grs = |grs_i;

    // Reserved modes 5..7 never increment and report no inexactness.
    always_comb begin
        illegal_o = rm_i[2] & (rm_i[1] | rm_i[0]);
        inexact_o = any_grs & ~illegal_o;
        inc_o     = (rm_i == RM_RNE) ? grs_i[2] & (lsb_i | grs_i[1] | grs_i[0]) :
                    (rm_i == RM_RDN) ? sign_i & any_grs :
                    (rm_i == RM_RUP) ? ~sign_i & any_grs :
                    (rm_i == RM_RMM) ? grs_i[2] : 1'b0;
    end

endmodule

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding pipeline with back-pressure, flush and tag
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = DP_EXP_W,
    parameter int FRAC_W = DP_FRAC_W,
    parameter int TAG_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W-1:0] in_exp_frac,
    input  logic [2:0]              in_grs,
    input  logic                    in_sign,
    input  logic [2:0]              in_rm,
    input  logic                    in_special,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [2:0]              frm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic [4:0]              out_flags,
    output logic                    out_illegal_rm,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int W = EXP_W + FRAC_W;

    logic [2:0]       eff_rm;
    logic             inc, illegal, inexact;
    logic             s1_adv, in_fire, s2_load, ovf, to_inf;
    logic [W-1:0]     mag;
    logic [4:0]       flags;

    logic             s1_valid_q, s1_valid_d;
    logic [W:0]       s1_sum_q, s1_sum_d;
    logic             s1_sign_q, s1_sign_d;
    logic [2:0]       s1_rm_q, s1_rm_d;
    logic             s1_illegal_q, s1_illegal_d;
    logic             s1_nx_q, s1_nx_d;
    logic             s1_special_q, s1_special_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [W:0]       s2_result_q, s2_result_d;
    logic [4:0]       s2_flags_q, s2_flags_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    assign eff_rm   = resolve_rm(in_rm, frm);
    assign s1_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s1_adv;
    assign in_fire  = in_valid & in_ready & ~flush;
    assign s2_load  = s1_adv & s1_valid_q & ~flush;

    fp_round_decide u_decide (
        .rm_i      (eff_rm),
        .sign_i    (in_sign),
        .lsb_i     (in_exp_frac[0]),
        .grs_i     (in_grs),
        .inc_o     (inc),
        .illegal_o (illegal),
        .inexact_o (inexact)
    );

    // S1: capture the effective mode and perform the rounding add; specials bypass it.
    always_comb begin
        s1_valid_d   = flush ? 1'b0 : in_fire ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
        s1_sum_d     = in_fire ? {1'b0, in_exp_frac} + {{W{1'b0}}, inc & ~in_special} : s1_sum_q;
        s1_sign_d    = in_fire ? in_sign : s1_sign_q;
        s1_rm_d      = in_fire ? eff_rm : s1_rm_q;
        s1_illegal_d = in_fire ? illegal & ~in_special : s1_illegal_q;
        s1_nx_d      = in_fire ? inexact & ~in_special : s1_nx_q;
        s1_special_d = in_fire ? in_special : s1_special_q;
        s1_tag_d     = in_fire ? in_tag : s1_tag_q;
    end

    // S2: detect exponent overflow, saturate to Inf or max-finite, and pack flags.
    always_comb begin
        ovf    = ~s1_special_q & ~s1_illegal_q & (s1_sum_q[W] | (&s1_sum_q[W-1:FRAC_W]));
        to_inf = (s1_rm_q == RM_RNE) | (s1_rm_q == RM_RMM) |
                 ((s1_rm_q == RM_RUP) & ~s1_sign_q) | ((s1_rm_q == RM_RDN) & s1_sign_q);
        mag    = ovf ? (to_inf ? {{EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                               : {{(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}})
                     : s1_sum_q[W-1:0];
        flags         = '0;
        flags[FLG_OF] = ovf;
        flags[FLG_NX] = s1_nx_q | ovf;
        s2_valid_d    = flush ? 1'b0 : s1_adv ? s1_valid_q : s2_valid_q;
        s2_result_d   = s2_load ? {s1_sign_q, mag} : s2_result_q;
        s2_flags_d    = s2_load ? flags : s2_flags_q;
        s2_illegal_d  = s2_load ? s1_illegal_q : s2_illegal_q;
        s2_tag_d      = s2_load ? s1_tag_q : s2_tag_q;
    end

    // Pipeline registers; reset discards every in-flight entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_rm_q      <= '0;
            s1_illegal_q <= 1'b0;
            s1_nx_q      <= 1'b0;
            s1_special_q <= 1'b0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
            s2_illegal_q <= 1'b0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_sign_q    <= s1_sign_d;
            s1_rm_q      <= s1_rm_d;
            s1_illegal_q <= s1_illegal_d;
            s1_nx_q      <= s1_nx_d;
            s1_special_q <= s1_special_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
            s2_illegal_q <= s2_illegal_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_result     = s2_result_q;
    assign out_flags      = s2_flags_q;
    assign out_illegal_rm = s2_illegal_q;
    assign out_tag        = s2_tag_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: scoreboard bench for the DP rounding pipe plus an SP instance
module tb_fp_round_pipe;
    import fp_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  flg;
        logic        ill;
        logic [5:0]  tag;
    } exp_t;

    logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic        in_sign = 0, in_special = 0;
    logic [62:0] in_exp_frac = '0;
    logic [2:0]  in_grs = '0, in_rm = '0, frm = '0;
    logic [5:0]  in_tag = '0;
    logic        in_ready, out_valid, out_illegal_rm;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic [5:0]  out_tag;

    logic        sp_in_valid = 0, sp_in_sign = 0, sp_in_special = 0;
    logic [30:0] sp_in_exp_frac = '0;
    logic [2:0]  sp_in_grs = '0, sp_in_rm = '0;
    logic [5:0]  sp_in_tag = '0;
    logic        sp_in_ready, sp_out_valid, sp_out_illegal_rm;
    logic [31:0] sp_out_result;
    logic [4:0]  sp_out_flags;
    logic [5:0]  sp_out_tag;

    int   n_checks = 0, n_fail = 0, n_out = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fp_round_pipe dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_exp_frac(in_exp_frac), .in_grs(in_grs), .in_sign(in_sign), .in_rm(in_rm),
        .in_special(in_special), .in_tag(in_tag), .frm(frm), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .out_illegal_rm(out_illegal_rm), .out_tag(out_tag)
    );

    fp_round_pipe #(.EXP_W(SP_EXP_W), .FRAC_W(SP_FRAC_W), .TAG_W(6)) dut_sp (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .in_exp_frac(sp_in_exp_frac), .in_grs(sp_in_grs), .in_sign(sp_in_sign), .in_rm(sp_in_rm),
        .in_special(sp_in_special), .in_tag(sp_in_tag), .frm(frm), .out_valid(sp_out_valid),
        .out_ready(out_ready), .out_result(sp_out_result), .out_flags(sp_out_flags),
        .out_illegal_rm(sp_out_illegal_rm), .out_tag(sp_out_tag)
    );

    // Reference DP rounding model evaluated at the moment an operation is accepted.
    function automatic exp_t model(input logic [62:0] ef, input logic [2:0] grs, input logic s,
                                   input logic [2:0] rm, input logic [2:0] fr, input logic sp,
                                   input logic [5:0] tag);
        exp_t e;
        logic [2:0] r;
        logic up;
        logic [63:0] sum;
        r = (rm == 3'd7) ? fr : rm;
        e.tag = tag;
        e.ill = 1'b0;
        e.flg = 5'b0;
        e.res = {s, ef};
        if (sp) return e;
        if (r > 3'd4) begin
            e.ill = 1'b1;
            return e;
        end
        case (r)
            3'd0:    up = grs[2] && (ef[0] || grs[1:0] != 2'b00);
            3'd1:    up = 1'b0;
            3'd2:    up = s && grs != 3'b000;
            3'd3:    up = !s && grs != 3'b000;
            default: up = grs[2];
        endcase
        sum = {1'b0, ef} + {63'd0, up};
        if (sum[63] || sum[62:52] == 11'h7FF) begin
            e.flg = 5'b00101;
            e.res = (r == 3'd0 || r == 3'd4 || (r == 3'd3 && !s) || (r == 3'd2 && s))
                    ? {s, 11'h7FF, 52'd0} : {s, 11'h7FE, {52{1'b1}}};
        end else begin
            e.res = {s, sum[62:0]};
            e.flg = {4'b0, grs != 3'b000};
        end
        return e;
    endfunction

    // Scoreboard: just before each rising edge, pop on output transfer and push on input transfer.
    always @(negedge clk) begin
        #4;
        if (out_valid && out_ready) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: tag=%0d res=%h, required no output", out_tag, out_result);
            end else begin
                mon_e = sbq.pop_front();
                n_out++;
                if ({out_result, out_flags, out_illegal_rm, out_tag} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_result: res=%h flg=%b ill=%b tag=%0d, required res=%h flg=%b ill=%b tag=%0d",
                             out_result, out_flags, out_illegal_rm, out_tag, mon_e.res, mon_e.flg, mon_e.ill, mon_e.tag);
                end
            end
        end
        if (in_valid && in_ready && !flush && !reset)
            sbq.push_back(model(in_exp_frac, in_grs, in_sign, in_rm, frm, in_special, in_tag));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input logic [62:0] ef, input logic [2:0] grs, input logic s, input logic [2:0] rm,
                          input logic [2:0] fr, input logic sp, input logic [5:0] tag);
        in_exp_frac = ef;
        in_grs      = grs;
        in_sign     = s;
        in_rm       = rm;
        frm         = fr;
        in_special  = sp;
        in_tag      = tag;
        in_valid    = 1'b1;
    endtask

    task automatic run1(input logic [62:0] ef, input logic [2:0] grs, input logic s, input logic [2:0] rm,
                        input logic [2:0] fr, input logic [5:0] tag, output logic [70:0] obs);
        cyc();
        set_op(ef, grs, s, rm, fr, 1'b0, tag);
        cyc();
        in_valid = 1'b0;
        cyc();
        obs = {out_valid, out_illegal_rm, out_flags, out_result};
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if ({out_valid, out_result, out_flags, out_illegal_rm, out_tag} !== 77'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: v=%b res=%h flg=%b ill=%b tag=%0d, required all zero",
                     out_valid, out_result, out_flags, out_illegal_rm, out_tag);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_rne();
        cyc();
        set_op(63'h3FF0_0000_0000_0001, 3'b100, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd1);
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rne_latency1: out_valid=%b, required 0", out_valid);
        end
        cyc();
        n_checks++;
        if ({out_valid, out_flags, out_result} !== {1'b1, 5'b00001, 64'h3FF0_0000_0000_0002}) begin
            n_fail++;
            $display("FAIL rne_result: v=%b flg=%b res=%h, required v=1 flg=00001 res=3ff0000000000002",
                     out_valid, out_flags, out_result);
        end
    endtask

    task automatic test_overflow();
        logic [70:0] o;
        run1({11'h7FE, {52{1'b1}}}, 3'b001, 1'b0, RM_RUP, 3'd0, 6'd2, o);
        n_checks++;
        if (o !== {1'b1, 1'b0, 5'b00101, 64'h7FF0_0000_0000_0000}) begin
            n_fail++;
            $display("FAIL of_rup_inf: got %h, required %h", o, {1'b1, 1'b0, 5'b00101, 64'h7FF0_0000_0000_0000});
        end
        run1({11'h7FE, {52{1'b1}}}, 3'b001, 1'b0, RM_RTZ, 3'd0, 6'd2, o);
        n_checks++;
        if (o !== {1'b1, 1'b0, 5'b00001, 64'h7FEF_FFFF_FFFF_FFFF}) begin
            n_fail++;
            $display("FAIL rz_no_carry: got %h, required %h", o, {1'b1, 1'b0, 5'b00001, 64'h7FEF_FFFF_FFFF_FFFF});
        end
        run1({11'h7FF, 52'd0}, 3'b000, 1'b0, RM_RTZ, 3'd0, 6'd2, o);
        n_checks++;
        if (o !== {1'b1, 1'b0, 5'b00101, 64'h7FEF_FFFF_FFFF_FFFF}) begin
            n_fail++;
            $display("FAIL of_rz_maxfinite: got %h, required %h", o, {1'b1, 1'b0, 5'b00101, 64'h7FEF_FFFF_FFFF_FFFF});
        end
        run1({11'h7FF, 52'h5}, 3'b010, 1'b1, RM_RDN, 3'd0, 6'd2, o);
        n_checks++;
        if (o !== {1'b1, 1'b0, 5'b00101, 64'hFFF0_0000_0000_0000}) begin
            n_fail++;
            $display("FAIL of_rdn_neg_inf: got %h, required %h", o, {1'b1, 1'b0, 5'b00101, 64'hFFF0_0000_0000_0000});
        end
        run1({11'h7FE, {52{1'b1}}}, 3'b001, 1'b1, RM_RUP, 3'd0, 6'd2, o);
        n_checks++;
        if (o !== {1'b1, 1'b0, 5'b00001, 64'hFFEF_FFFF_FFFF_FFFF}) begin
            n_fail++;
            $display("FAIL rup_neg_trunc: got %h, required %h", o, {1'b1, 1'b0, 5'b00001, 64'hFFEF_FFFF_FFFF_FFFF});
        end
    endtask

    task automatic test_dyn();
        logic [70:0] o;
        cyc();
        set_op(63'h4000_0000_0000_0000, 3'b011, 1'b1, RM_DYN, 3'b010, 1'b0, 6'd3);
        cyc();
        in_valid = 1'b0;
        frm = 3'b101;
        cyc();
        n_checks++;
        if ({out_valid, out_illegal_rm, out_flags, out_result} !== {1'b1, 1'b0, 5'b00001, 1'b1, 63'h4000_0000_0000_0001}) begin
            n_fail++;
            $display("FAIL dyn_frm_capture: v=%b ill=%b flg=%b res=%h, required v=1 ill=0 flg=00001 res=c000000000000001",
                     out_valid, out_illegal_rm, out_flags, out_result);
        end
        run1(63'h4123_4567_89AB_CDEF, 3'b111, 1'b1, RM_DYN, 3'b101, 6'd4, o);
        n_checks++;
        if (o !== {1'b1, 1'b1, 5'b00000, 1'b1, 63'h4123_4567_89AB_CDEF}) begin
            n_fail++;
            $display("FAIL dyn_illegal: got %h, required %h", o, {1'b1, 1'b1, 5'b00000, 1'b1, 63'h4123_4567_89AB_CDEF});
        end
    endtask

    task automatic test_back_to_back();
        int base = n_out;
        int k = 0;
        int sent = 0;
        bit took = 0;
        bit saw_low = 0;
        logic pv = 0, pr = 1;
        logic [63:0] pres = '0;
        logic [5:0] ptag = '0;
        while (n_out - base < 8 && k < 80) begin
            cyc();
            k++;
            if (pv && !pr) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_result !== pres || out_tag !== ptag) begin
                    n_fail++;
                    $display("FAIL stall_stable: v=%b res=%h tag=%0d, required v=1 res=%h tag=%0d",
                             out_valid, out_result, out_tag, pres, ptag);
                end
            end
            pv = out_valid;
            pres = out_result;
            ptag = out_tag;
            out_ready = !(k >= 5 && k <= 7);
            pr = out_ready;
            if (took) sent++;
            if (sent >= 8) in_valid = 1'b0;
            else if (took || k == 1)
                set_op({31'($urandom), 32'($urandom)}, 3'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, 6'(10 + sent));
            #1;
            took = in_valid && in_ready;
            if (in_valid && !in_ready) saw_low = 1;
        end
        n_checks++;
        if (n_out - base !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required 8", n_out - base);
        end
        n_checks++;
        if (saw_low !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready_drop: saw_low=%b, required 1", saw_low);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_flush();
        bit seen = 0;
        out_ready = 1'b0;
        cyc();
        set_op(63'h1234, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd40);
        cyc();
        set_op(63'h5678, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd41);
        cyc();
        set_op(63'h9ABC, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd42);
        flush = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_full: out_valid=%b, required 1", out_valid);
        end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: out_valid=%b, required 0", out_valid);
        end
        repeat (4) begin
            cyc();
            if (out_valid) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_tags: output seen=%b, required 0", seen);
        end
        set_op(63'h1111, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd43);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop_input: out_valid=%b tag=%0d, required 0", out_valid, out_tag);
        end
    endtask

    task automatic test_sp();
        cyc();
        sp_in_exp_frac = 31'h7FC0_0000;
        sp_in_grs = 3'b111;
        sp_in_sign = 1'b0;
        sp_in_rm = RM_RNE;
        sp_in_special = 1'b1;
        sp_in_tag = 6'd7;
        sp_in_valid = 1'b1;
        n_checks++;
        if (sp_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sp_in_ready: got %b, required 1", sp_in_ready);
        end
        cyc();
        sp_in_valid = 1'b0;
        cyc();
        n_checks++;
        if ({sp_out_valid, sp_out_illegal_rm, sp_out_flags, sp_out_result, sp_out_tag} !== {1'b1, 1'b0, 5'b0, 32'h7FC0_0000, 6'd7}) begin
            n_fail++;
            $display("FAIL sp_special: v=%b ill=%b flg=%b res=%h tag=%0d, required v=1 ill=0 flg=00000 res=7fc00000 tag=7",
                     sp_out_valid, sp_out_illegal_rm, sp_out_flags, sp_out_result, sp_out_tag);
        end
        sp_in_exp_frac = 31'h3F7F_FFFF;
        sp_in_grs = 3'b100;
        sp_in_special = 1'b0;
        sp_in_tag = 6'd8;
        sp_in_valid = 1'b1;
        cyc();
        sp_in_valid = 1'b0;
        cyc();
        n_checks++;
        if ({sp_out_valid, sp_out_flags, sp_out_result, sp_out_tag} !== {1'b1, 5'b00001, 32'h3F80_0000, 6'd8}) begin
            n_fail++;
            $display("FAIL sp_rne_carry: v=%b flg=%b res=%h tag=%0d, required v=1 flg=00001 res=3f800000 tag=8",
                     sp_out_valid, sp_out_flags, sp_out_result, sp_out_tag);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        cyc();
        set_op(63'h3FF8_0000_0000_0000, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd50);
        cyc();
        set_op(63'h3FF8_0000_0000_0001, 3'b000, 1'b0, RM_RNE, 3'd0, 1'b0, 6'd51);
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 6'd50) begin
            n_fail++;
            $display("FAIL arst_pre: v=%b tag=%0d, required v=1 tag=50", out_valid, out_tag);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_result, out_flags, out_illegal_rm, out_tag} !== 77'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: v=%b res=%h flg=%b ill=%b tag=%0d, required all zero",
                     out_valid, out_result, out_flags, out_illegal_rm, out_tag);
        end
        sbq.delete();
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_s1_cleared: out_valid=%b tag=%0d, required 0", out_valid, out_tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rne();
        test_overflow();
        test_dyn();
        test_back_to_back();
        test_flush();
        test_sp();
        test_async_reset();
        repeat (3) cyc();
        n_checks++;
        if (sbq.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drained: %0d entries left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
